// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared redirect classes, FSM encoding and trap vector
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Ordered so that a numerically larger class is an older instruction
  typedef enum logic [1:0] {
    c_cls_none = 2'd0,
    c_cls_id   = 2'd1,
    c_cls_ex   = 2'd2,
    c_cls_trap = 2'd3
  } redirect_cls_t;

  localparam logic [0:0] c_st_idle    = 1'b0;
  localparam logic [0:0] c_st_pending = 1'b1;

  localparam logic [31:0] c_trap_vec_default = 32'h0000_0004;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : CNT_W-bit up-counter that sticks at all-ones
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (inc && (r_value != {CNT_W{1'b1}})) begin
      r_value <= r_value + c_one;
    end
  end

  assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// branch_redirect_ctrl : oldest-first PC redirect arbiter with flush pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = c_trap_vec_default,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trap_valid,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  input  logic             ex_jalr_valid,
  input  logic [31:0]      ex_target,
  input  logic             id_jal_valid,
  input  logic [31:0]      id_target,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             misalign_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [0:0]    r_state;
  redirect_cls_t r_cls;
  logic [31:0]   r_pc;
  logic          r_flush_if;
  logic          r_flush_id;
  logic          r_flush_ex;
  logic          r_misalign;

  logic          w_ex_req;
  logic          w_br_taken;
  logic [31:0]   w_ex_tgt;
  logic [31:0]   w_id_tgt;
  redirect_cls_t w_req_cls;
  logic [31:0]   w_req_pc;
  logic          w_req_mis;
  logic          w_accept;

  assign w_br_taken = ex_br_valid & ex_br_taken;
  assign w_ex_req   = ex_jalr_valid | w_br_taken;
  assign w_ex_tgt   = ex_target & ~32'h1;
  assign w_id_tgt   = id_target & ~32'h1;

  // Only the oldest request survives; a misaligned target becomes a trap
  always_comb begin
    w_req_cls = c_cls_none;
    w_req_pc  = '0;
    w_req_mis = 1'b0;
    if (trap_valid) begin
      w_req_cls = c_cls_trap;
      w_req_pc  = TRAP_VEC;
    end else if (w_ex_req) begin
      if (w_ex_tgt[1]) begin
        w_req_cls = c_cls_trap;
        w_req_pc  = TRAP_VEC;
        w_req_mis = 1'b1;
      end else begin
        w_req_cls = c_cls_ex;
        w_req_pc  = w_ex_tgt;
      end
    end else if (id_jal_valid) begin
      if (w_id_tgt[1]) begin
        w_req_cls = c_cls_trap;
        w_req_pc  = TRAP_VEC;
        w_req_mis = 1'b1;
      end else begin
        w_req_cls = c_cls_id;
        w_req_pc  = w_id_tgt;
      end
    end
  end

  // While pending, only a strictly older request may overwrite the held one
  assign w_accept = (r_state == c_st_idle) ? (w_req_cls != c_cls_none)
                                           : (w_req_cls > r_cls);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_cls      <= c_cls_none;
      r_pc       <= '0;
      r_flush_if <= 1'b0;
      r_flush_id <= 1'b0;
      r_flush_ex <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (w_accept) begin
        r_state    <= c_st_pending;
        r_cls      <= w_req_cls;
        r_pc       <= w_req_pc;
        r_flush_if <= 1'b1;
        r_flush_id <= (w_req_cls == c_cls_ex) || (w_req_cls == c_cls_trap);
        r_flush_ex <= (w_req_cls == c_cls_trap);
        r_misalign <= w_req_mis;
      end else if ((r_state == c_st_pending) && fetch_ready) begin
        r_state    <= c_st_idle;
        r_cls      <= c_cls_none;
        r_flush_if <= 1'b0;
        r_flush_id <= 1'b0;
        r_flush_ex <= 1'b0;
      end else begin
        // Holding: keep IF squashed until the redirect is taken
        r_flush_if <= (r_state == c_st_pending);
        r_flush_id <= 1'b0;
        r_flush_ex <= 1'b0;
      end
    end
  end

  assign redirect_valid = (r_state == c_st_pending);
  assign redirect_pc    = r_pc;
  assign flush_if       = r_flush_if;
  assign flush_id       = r_flush_id;
  assign flush_ex       = r_flush_ex;
  assign misalign_err   = r_misalign;

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ex_br_valid),
    .value (br_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_br_taken),
    .value (taken_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// ============================================================================
// tb_branch_redirect_ctrl : directed checks of arbitration, hold and counters
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_redirect_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             trap_valid;
  logic             ex_br_valid;
  logic             ex_br_taken;
  logic             ex_jalr_valid;
  logic [31:0]      ex_target;
  logic             id_jal_valid;
  logic [31:0]      id_target;
  logic             fetch_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if;
  logic             flush_id;
  logic             flush_ex;
  logic             misalign_err;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  int total = 0;
  int bad   = 0;

  branch_redirect_ctrl #(.TRAP_VEC(32'h0000_0004), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trap_valid     (trap_valid),
    .ex_br_valid    (ex_br_valid),
    .ex_br_taken    (ex_br_taken),
    .ex_jalr_valid  (ex_jalr_valid),
    .ex_target      (ex_target),
    .id_jal_valid   (id_jal_valid),
    .id_target      (id_target),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .misalign_err   (misalign_err),
    .br_cnt         (br_cnt),
    .taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // valid, pc, flush_if/id/ex, misalign
  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic fi, input logic fd, input logic fe, input logic me);
    chk({tag, ".valid"}, {31'd0, redirect_valid}, {31'd0, v});
    chk({tag, ".pc"}, redirect_pc, pc);
    chk({tag, ".flush"}, {29'd0, flush_if, flush_id, flush_ex}, {29'd0, fi, fd, fe});
    chk({tag, ".mis"}, {31'd0, misalign_err}, {31'd0, me});
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] t);
    chk({tag, ".br_cnt"}, {{(32-CNT_W){1'b0}}, br_cnt}, {{(32-CNT_W){1'b0}}, b});
    chk({tag, ".taken_cnt"}, {{(32-CNT_W){1'b0}}, taken_cnt}, {{(32-CNT_W){1'b0}}, t});
  endtask

  task automatic clr();
    trap_valid    = 1'b0;
    ex_br_valid   = 1'b0;
    ex_br_taken   = 1'b0;
    ex_jalr_valid = 1'b0;
    ex_target     = '0;
    id_jal_valid  = 1'b0;
    id_target     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    fetch_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("reset", 4'h0, 4'h0);
    rst_n = 1'b1;

    // EX taken branch, consumed immediately
    ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_target = 32'h0000_0100;
    tick();
    chk_out("ex_br", 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_cnt("ex_br", 4'h1, 4'h1);
    clr();
    tick();
    chk_out("ex_br_done", 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);

    // JAL and JALR together: JALR wins, bit0 cleared
    id_jal_valid = 1'b1; id_target = 32'h0000_0200;
    ex_jalr_valid = 1'b1; ex_target = 32'h0000_0301;
    tick();
    chk_out("jalr_vs_jal", 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
    clr();
    tick();
    chk_out("jalr_done", 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);

    // ID redirect held for 3 cycles, then trap overrides
    fetch_ready = 1'b0;
    id_jal_valid = 1'b1; id_target = 32'h0000_0040;
    tick();
    chk_out("jal", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    clr();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("jal_hold", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    trap_valid = 1'b1;
    tick();
    chk_out("trap_over", 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0);
    clr();
    fetch_ready = 1'b1;
    tick();
    chk_out("trap_done", 1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Misaligned EX target becomes a trap
    ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_target = 32'h0000_0102;
    tick();
    chk_out("misalign", 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_cnt("misalign", 4'h2, 4'h2);
    clr();
    tick();
    chk_out("misalign_done", 1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Equal class ignored while pending; older class replaces with fetch_ready
    fetch_ready = 1'b0;
    id_jal_valid = 1'b1; id_target = 32'h0000_0080;
    tick();
    id_target = 32'h0000_0090;
    tick();
    chk_out("eq_ignored", 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    clr();
    ex_jalr_valid = 1'b1; ex_target = 32'h0000_0500; fetch_ready = 1'b1;
    tick();
    chk_out("replace_ready", 1'b1, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0);
    clr();
    tick();
    chk_out("replace_done", 1'b0, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while pending
    fetch_ready = 1'b0;
    id_jal_valid = 1'b1; id_target = 32'h0000_0060;
    tick();
    chk_out("pre_rst", 1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0);
    clr();
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("async_rst", 4'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    fetch_ready = 1'b1;
    ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_target = 32'h0000_0180;
    tick();
    chk_out("post_rst", 1'b1, 32'h180, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_cnt("post_rst", 4'h1, 4'h1);

    // Saturating counters
    for (int i = 0; i < 4; i++) tick();
    chk_cnt("cnt5", 4'h5, 4'h5);
    ex_br_taken = 1'b0;
    tick();
    chk_cnt("cnt_nt", 4'h6, 4'h5);
    ex_br_taken = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk_cnt("cnt_sat", 4'hF, 4'hF);
    ex_br_taken = 1'b0;
    tick();
    chk_cnt("cnt_sat_nt", 4'hF, 4'hF);
    clr();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
